// File: rtl/ysyx_2022040010_if_fetch_pkg.sv
// Shared defaults and helpers for the instruction-fetch slice.
package ysyx_2022040010_if_fetch_pkg;

    localparam int          PC_W_DEF     = 64;
    localparam int          INST_W_DEF   = 32;
    localparam logic [63:0] PC_START_DEF = 64'h8000_0000;

    // Width of the IF-to-ID bundle: {pc, inst}
    function automatic int if_id_w(input int pc_w, input int inst_w);
        return pc_w + inst_w;
    endfunction

    // Counters must hold the value n itself, hence the extra bit
    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

    typedef enum logic [1:0] {
        RSP_NONE,
        RSP_KEEP,
        RSP_DROP,
        RSP_ERR
    } rsp_kind_e;

endpackage

// File: rtl/ysyx_2022040010_sync_fifo.sv
// Small synchronous FIFO with flush; empty head reads as zero.
module ysyx_2022040010_sync_fifo
    import ysyx_2022040010_if_fetch_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rptr;
    logic [AW-1:0] wptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // Push into a full FIFO is fine when the head leaves the same cycle
    assign do_push = push & (~full | do_pop);
    assign rdata   = empty ? '0 : mem[rptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else if (flush) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wptr] <= wdata;
    end

    always @(posedge clk) begin
        if (rst) begin
            assert (!(pop && empty && !flush));
            assert (!(push && full && !pop && !flush));
        end
    end

endmodule

// File: rtl/ysyx_2022040010_if_fetch.sv
// IF stage: PC generator, icache handshake with credit-based flow
// control, and an in-order fetch buffer feeding ID.
module ysyx_2022040010_if_fetch
    import ysyx_2022040010_if_fetch_pkg::*;
#(
    parameter int          PC_W     = PC_W_DEF,
    parameter int          INST_W   = INST_W_DEF,
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUT  = 2,
    parameter logic [63:0] PC_START = PC_START_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              br_e,
    input  logic [PC_W-1:0]   br_addr,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [PC_W-1:0]   req_addr,
    input  logic              resp_valid,
    input  logic [INST_W-1:0] resp_inst,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [PC_W-1:0]   id_pc,
    output logic [INST_W-1:0] id_inst
);

    localparam int CW    = cnt_w(MAX_OUT);
    localparam int BW    = cnt_w(DEPTH);
    localparam int SW    = ((CW > BW) ? CW : BW) + 1;
    localparam int BUF_W = if_id_w(PC_W, INST_W);
    localparam logic [PC_W-1:0] PC_RST = PC_START[PC_W-1:0];

    logic [PC_W-1:0]  pc_r;
    logic [CW-1:0]    out_cnt;
    logic [CW-1:0]    drop_cnt;
    logic [BW-1:0]    buf_cnt;
    logic [SW-1:0]    credit;
    rsp_kind_e        rsp_kind;
    logic             fire;
    logic             rsp_take;
    logic             has_out;

    logic [PC_W-1:0]  pend_head;
    logic             pend_full;
    logic             pend_empty;
    logic [CW-1:0]    pend_cnt;

    logic [BUF_W-1:0] buf_wdata;
    logic [BUF_W-1:0] buf_rdata;
    logic             buf_push;
    logic             buf_pop;
    logic             buf_full;
    logic             buf_empty;

    // Outstanding requests already own a buffer slot
    assign credit    = SW'(out_cnt) + SW'(buf_cnt);
    assign req_valid = rst & ~hold & ~br_e
                     & (out_cnt < CW'(MAX_OUT))
                     & (credit < SW'(DEPTH));
    assign req_addr  = pc_r;
    assign fire      = req_valid & req_ready;
    assign has_out   = (out_cnt != '0);

    always_comb begin
        rsp_kind = RSP_NONE;
        unique case (1'b1)
            !resp_valid:
                rsp_kind = RSP_NONE;
            resp_valid && !has_out:
                rsp_kind = RSP_ERR;
            resp_valid && has_out && (br_e || drop_cnt != '0):
                rsp_kind = RSP_DROP;
            resp_valid && has_out && !br_e && drop_cnt == '0:
                rsp_kind = RSP_KEEP;
        endcase
    end

    assign rsp_take  = (rsp_kind == RSP_KEEP) | (rsp_kind == RSP_DROP);
    assign buf_push  = (rsp_kind == RSP_KEEP);
    assign buf_pop   = id_valid & id_ready & ~br_e;
    assign buf_wdata = {pend_head, resp_inst};

    assign id_valid  = ~buf_empty;
    assign id_pc     = buf_rdata[BUF_W-1:INST_W];
    assign id_inst   = buf_rdata[INST_W-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_r     <= PC_RST;
            out_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            out_cnt <= out_cnt + CW'(fire) - CW'(rsp_take);
            if (br_e) begin
                pc_r     <= br_addr & ~PC_W'(3);
                drop_cnt <= out_cnt - CW'(rsp_take);
            end else begin
                if (fire) pc_r <= pc_r + PC_W'(4);
                if (rsp_kind == RSP_DROP)
                    drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

    // Killed responses are not popped here: the flush already removed
    // their PCs, and the queue may by now hold new-stream PCs.
    ysyx_2022040010_sync_fifo #(
        .W     (PC_W),
        .DEPTH (MAX_OUT)
    ) u_pend (
        .clk   (clk),
        .rst   (rst),
        .push  (fire),
        .pop   (buf_push),
        .flush (br_e),
        .wdata (pc_r),
        .rdata (pend_head),
        .full  (pend_full),
        .empty (pend_empty),
        .count (pend_cnt)
    );

    ysyx_2022040010_sync_fifo #(
        .W     (BUF_W),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (buf_push),
        .pop   (buf_pop),
        .flush (br_e),
        .wdata (buf_wdata),
        .rdata (buf_rdata),
        .full  (buf_full),
        .empty (buf_empty),
        .count (buf_cnt)
    );

    always @(posedge clk) begin
        if (rst) begin
            assert (rsp_kind != RSP_ERR);
            assert (!(buf_push && pend_empty));
            assert (!(fire && pend_full && !br_e));
            assert (pend_cnt <= out_cnt);
            assert (!(buf_push && buf_full && !buf_pop));
            assert (!(rsp_take && !has_out));
            assert (!(rsp_kind == RSP_DROP && !br_e
                      && drop_cnt == '0));
        end
    end

endmodule
